// File: rtl/boot_loader.sv
// boot_loader
//   Serial ROM loader sitting between the UART receiver and the instruction
//   ROM. Parses a framed image from the received byte stream:
//     SYNC | N[7:0] | N[15:8] | N x 32-bit little-endian words | checksum
//   The checksum is the mod-256 sum of the payload (word) bytes only.
//   Each completed word is written to the ROM one cycle after its last byte.
//   The CPU is held in reset from SYNC until a frame with a good checksum
//   completes; failures (bad checksum, inter-byte timeout, ROM overflow) set
//   a sticky err that the next SYNC clears.
//
// Ports
//   clk, rst   system clock, asynchronous active-high reset
//   rx_data    received byte, qualified by rx_tick
//   rx_tick    one-cycle strobe per byte (back-to-back allowed)
//   rom_wen    one-cycle ROM write strobe
//   rom_addr   word-aligned ROM byte address (held when rom_wen=0)
//   rom_wdata  ROM write data (held when rom_wen=0)
//   cpu_rst    reset request to the CPU while a load is pending/failed
//   busy       high whenever a frame is being parsed
//   err        sticky failure flag for the last frame
//   done       one-cycle pulse on successful frame completion
module boot_loader #(
  parameter int         ADDR_WIDTH     = 14,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_tick,
  output logic                  rom_wen,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic [31:0]           rom_wdata,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  err,
  output logic                  done
);

  localparam int CAP = 2 ** (ADDR_WIDTH - 2);  // ROM capacity in words
  localparam int TW  = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM
  } state_t;

  state_t        state, state_nxt;

  logic [15:0]   len_q;     // frame word count N
  logic [15:0]   word_idx;  // index of the word being assembled
  logic [1:0]    byte_idx;  // byte position inside the current word
  logic [7:0]    csum;      // running payload checksum
  logic [23:0]   word_sr;   // first three bytes of the current word
  logic [TW-1:0] tmo_cnt;   // idle cycles since the last byte
  logic          ovf;       // a word fell beyond ROM capacity this frame

  // decoded events
  logic sync_hit, expire, word_done, last_word, in_range, csum_tick, csum_ok;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: every transition is byte driven except the timeout.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (sync_hit) state_nxt = S_LEN0;
      S_LEN0: if (rx_tick)  state_nxt = S_LEN1;
      S_LEN1: if (rx_tick)
                state_nxt = ({rx_data, len_q[7:0]} == 16'd0) ? S_CSUM : S_DATA;
      S_DATA: if (last_word) state_nxt = S_CSUM;
      S_CSUM: if (rx_tick)  state_nxt = S_IDLE;
      default:              state_nxt = S_IDLE;
    endcase
    // An arriving byte always beats the timeout (expire is gated by !rx_tick).
    if (expire) state_nxt = S_IDLE;
  end

  // ---------------------------------------------------------------------------
  // Output / event decode
  // ---------------------------------------------------------------------------
  always_comb begin
    busy      = (state != S_IDLE);
    sync_hit  = (state == S_IDLE) && rx_tick && (rx_data == SYNC_BYTE);
    expire    = busy && !rx_tick && (tmo_cnt == TMO_LAST);
    word_done = (state == S_DATA) && rx_tick && (byte_idx == 2'd3);
    last_word = word_done && ((word_idx + 16'd1) == len_q);
    in_range  = (int'(word_idx) < CAP);
    csum_tick = (state == S_CSUM) && rx_tick;
    csum_ok   = (rx_data == csum) && !ovf;
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q     <= '0;
      word_idx  <= '0;
      byte_idx  <= '0;
      csum      <= '0;
      word_sr   <= '0;
      tmo_cnt   <= '0;
      ovf       <= 1'b0;
      rom_wen   <= 1'b0;
      rom_addr  <= '0;
      rom_wdata <= '0;
      cpu_rst   <= 1'b0;
      err       <= 1'b0;
      done      <= 1'b0;
    end else begin
      rom_wen <= 1'b0;
      done    <= 1'b0;

      // inter-byte watchdog, only live while parsing a frame
      if (!busy || rx_tick) tmo_cnt <= '0;
      else if (!expire)     tmo_cnt <= tmo_cnt + 1'b1;

      if (sync_hit) begin
        cpu_rst  <= 1'b1;
        err      <= 1'b0;
        csum     <= '0;
        word_idx <= '0;
        byte_idx <= '0;
        ovf      <= 1'b0;
      end

      if (state == S_LEN0 && rx_tick) len_q[7:0]  <= rx_data;
      if (state == S_LEN1 && rx_tick) len_q[15:8] <= rx_data;

      if (state == S_DATA && rx_tick) begin
        csum     <= csum + rx_data;
        byte_idx <= byte_idx + 2'd1;
        word_sr  <= {rx_data, word_sr[23:8]};
        if (word_done) begin
          word_idx <= word_idx + 16'd1;
          if (in_range) begin
            rom_wen   <= 1'b1;
            rom_addr  <= {word_idx[ADDR_WIDTH-3:0], 2'b00};
            rom_wdata <= {rx_data, word_sr};
          end else begin
            // keep parsing to the checksum, but the frame can no longer pass
            err <= 1'b1;
            ovf <= 1'b1;
          end
        end
      end

      if (csum_tick) begin
        if (csum_ok) begin
          cpu_rst <= 1'b0;
          done    <= 1'b1;
        end else begin
          err <= 1'b1;
        end
      end

      // partial word is dropped implicitly: the next SYNC resets byte_idx
      if (expire) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader. Two instances share the byte stream: one with the
// default 4096-word ROM, one with a 4-word ROM to exercise overflow. A
// frame-level model derives, from the frame bytes alone, which writes and
// done pulses must appear and on which cycle; one negedge process checks
// them. End-of-frame status and a few literal values are checked directly.
module tb_boot_loader;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_tick;

  logic        a_wen, a_cpu, a_busy, a_err, a_done;
  logic [13:0] a_addr;
  logic [31:0] a_wdata;
  logic        b_wen, b_cpu, b_busy, b_err, b_done;
  logic [3:0]  b_addr;
  logic [31:0] b_wdata;

  boot_loader #(.ADDR_WIDTH(14), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(T)) dut_a (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_tick(rx_tick),
    .rom_wen(a_wen), .rom_addr(a_addr), .rom_wdata(a_wdata),
    .cpu_rst(a_cpu), .busy(a_busy), .err(a_err), .done(a_done));

  boot_loader #(.ADDR_WIDTH(4), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(T)) dut_b (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_tick(rx_tick),
    .rom_wen(b_wen), .rom_addr(b_addr), .rom_wdata(b_wdata),
    .cpu_rst(b_cpu), .busy(b_busy), .err(b_err), .done(b_done));

  always #5 clk = ~clk;

  typedef struct { int d; int at; logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct { int d; int at; } ev_t;

  wr_t        wq[$];
  ev_t        dq[$];
  logic [7:0] fr[$];
  int         cap[2] = '{4096, 4};
  bit         exp_err[2], exp_cpu[2];
  int         checks = 0, failures = 0, neg_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Match one instance's write/done activity against the expected events.
  task automatic cmp_port(input int d, input logic wen, input logic [31:0] addr,
                          input logic [31:0] data, input logic dn);
    int wi = -1, di = -1;
    foreach (wq[i]) if (wi < 0 && wq[i].d == d) wi = i;
    foreach (dq[i]) if (di < 0 && dq[i].d == d) di = i;
    if (wen) begin
      if (wi < 0) begin
        checks++; failures++;
        $display("FAIL unexpected_wen dut%0d: got addr %h data %h expected no write", d, addr, data);
      end else begin
        chk($sformatf("wr_cycle dut%0d", d), neg_cnt, wq[wi].at);
        chk($sformatf("wr_addr dut%0d", d), addr, wq[wi].addr);
        chk($sformatf("wr_data dut%0d", d), data, wq[wi].data);
        wq.delete(wi);
      end
    end else if (wi >= 0 && wq[wi].at <= neg_cnt) begin
      checks++; failures++;
      $display("FAIL missing_wen dut%0d: got none expected write %h at cycle %0d", d, wq[wi].data, wq[wi].at);
      wq.delete(wi);
    end
    if (dn) begin
      if (di < 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done dut%0d: got 1 expected 0", d);
      end else begin
        chk($sformatf("done_cycle dut%0d", d), neg_cnt, dq[di].at);
        dq.delete(di);
      end
    end else if (di >= 0 && dq[di].at <= neg_cnt) begin
      checks++; failures++;
      $display("FAIL missing_done dut%0d: got 0 expected 1 at cycle %0d", d, dq[di].at);
      dq.delete(di);
    end
  endtask

  always @(negedge clk) begin
    neg_cnt++;
    if (!rst) begin
      cmp_port(0, a_wen, 32'(a_addr), a_wdata, a_done);
      cmp_port(1, b_wen, 32'(b_addr), b_wdata, b_done);
    end
  end

  // load fr with the last n bytes of v, first byte most significant
  task automatic from_hex(input logic [511:0] v, input int n);
    fr.delete();
    for (int i = 0; i < n; i++) fr.push_back(v[8*(n-1-i) +: 8]);
  endtask

  // build a frame from words; bad=1 corrupts the checksum
  task automatic build_frame(input logic [31:0] w[$], input bit bad);
    logic [7:0] s = 8'h00;
    fr.delete();
    fr.push_back(8'hA5);
    fr.push_back(8'(w.size()));
    fr.push_back(8'(w.size() >> 8));
    foreach (w[k])
      for (int j = 0; j < 4; j++) begin
        fr.push_back(w[k][8*j +: 8]);
        s += w[k][8*j +: 8];
      end
    fr.push_back(bad ? s + 8'h01 : s);
  endtask

  // Send fr (a SYNC-led frame, possibly truncated) with gap idle cycles
  // between bytes; expectations are queued as each byte is sampled.
  // Entered and left just after a rising edge.
  task automatic send_frame(input int gap);
    int         n = int'({fr[2], fr[1]});
    int         clen = 4 + 4*n;
    logic [7:0] s = 8'h00;
    for (int i = 3; i < 3 + 4*n && i < fr.size(); i++) s += fr[i];
    foreach (fr[i]) begin
      rx_data = fr[i];
      rx_tick = 1'b1;
      @(posedge clk);
      if (i >= 3 && i < 3 + 4*n && ((i - 3) % 4) == 3) begin
        int w = (i - 3) / 4;
        for (int d = 0; d < 2; d++)
          if (w < cap[d])
            wq.push_back('{d, neg_cnt + 1, 32'(w * 4),
                           {fr[i], fr[i-1], fr[i-2], fr[i-3]}});
      end
      if (i == clen - 1)
        for (int d = 0; d < 2; d++)
          if (fr[i] == s && n <= cap[d]) dq.push_back('{d, neg_cnt + 1});
      #1 rx_tick = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    for (int d = 0; d < 2; d++) begin
      bit ok = (fr.size() == clen) && (fr[clen-1] == s) && (n <= cap[d]);
      exp_err[d] = !ok;
      exp_cpu[d] = !ok;
    end
  endtask

  task automatic end_check(input string tag);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, " busy_a"}, a_busy, 0);
    chk({tag, " busy_b"}, b_busy, 0);
    chk({tag, " err_a"}, a_err, exp_err[0]);
    chk({tag, " err_b"}, b_err, exp_err[1]);
    chk({tag, " cpu_rst_a"}, a_cpu, exp_cpu[0]);
    chk({tag, " cpu_rst_b"}, b_cpu, exp_cpu[1]);
    chk({tag, " pending"}, wq.size() + dq.size(), 0);
  endtask

  initial begin
    logic [31:0] w[$];
    rst = 1'b1; rx_tick = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst wen_a", a_wen, 0);      chk("rst wen_b", b_wen, 0);
    chk("rst cpu_rst_a", a_cpu, 0);  chk("rst cpu_rst_b", b_cpu, 0);
    chk("rst busy_a", a_busy, 0);    chk("rst err_a", a_err, 0);
    chk("rst done_a", a_done, 0);    chk("rst addr_a", a_addr, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // noise without SYNC is ignored
    for (int i = 0; i < 3; i++) begin
      rx_data = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : 8'h12;
      rx_tick = 1'b1;
      @(posedge clk); #1 rx_tick = 1'b0;
    end
    @(posedge clk); #1;
    chk("noise busy_a", a_busy, 0);
    chk("noise cpu_rst_a", a_cpu, 0);

    // two-word frame, checksum hand computed (payload sum = 0x4C)
    from_hex({8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
              8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4C}, 12);
    send_frame(1);
    end_check("good");
    chk("good lit addr", a_addr, 14'h0004);
    chk("good lit data", a_wdata, 32'hDEADBEEF);
    chk("good lit err", a_err, 0);

    // same frame, bad checksum: writes still land, CPU stays held
    from_hex({8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
              8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h21}, 12);
    send_frame(0);
    end_check("badcs");
    chk("badcs lit err", a_err, 1);
    chk("badcs lit cpu_rst", a_cpu, 1);

    // good frame back-to-back recovers
    from_hex({8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
              8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4C}, 12);
    send_frame(0);
    end_check("recover");

    // truncated frame: watchdog fires after T idle cycles
    from_hex({8'hA5, 8'h01, 8'h00, 8'h11, 8'h22}, 5);
    send_frame(0);
    repeat (T - 1) @(posedge clk);
    #1 chk("tmo still busy", a_busy, 1);
    @(posedge clk);
    #1 chk("tmo expired busy", a_busy, 0);
    chk("tmo lit err", a_err, 1);
    end_check("timeout");

    // gaps of T-1 idle cycles: byte coincides with expiry and wins
    w = '{32'h01020304};
    build_frame(w, 1'b0);
    send_frame(T - 1);
    end_check("gapmax");

    // empty frames, spaced and back-to-back
    from_hex({8'hA5, 8'h00, 8'h00, 8'h00}, 4);
    send_frame(1);
    end_check("n0 spaced");
    send_frame(0);
    end_check("n0 b2b");

    // five words: overflows the 4-word ROM; SYNC value as payload data
    w = '{32'hA5A5A5A5, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    build_frame(w, 1'b0);
    send_frame(0);
    end_check("ovf");
    chk("ovf lit addr_b", b_addr, 4'hC);
    chk("ovf lit data_b", b_wdata, 32'h33333333);
    chk("ovf lit err_b", b_err, 1);
    chk("ovf lit addr_a", a_addr, 14'h0010);

    // reset in the middle of DATA
    from_hex({8'hA5, 8'h02, 8'h00, 8'h11, 8'h22}, 5);
    send_frame(0);
    chk("mid busy", a_busy, 1);
    rst = 1'b1;
    #1;
    chk("midrst cpu_rst_a", a_cpu, 0);
    chk("midrst cpu_rst_b", b_cpu, 0);
    chk("midrst busy_a", a_busy, 0);
    chk("midrst busy_b", b_busy, 0);
    chk("midrst err_b", b_err, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("post pending", wq.size() + dq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end
endmodule
